// File: rtl/game_pkg.sv
// Shared game constants and types used by the draw engines.
//   Screen geometry, colour index width, sprite geometry, framebuffer
//   address width, the transparent colour index and the sprite FSM states.
package game_pkg;

  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned SCREEN_H   = 480;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned SPR_W      = 32;
  localparam int unsigned SPR_H      = 32;
  localparam int unsigned NUM_FRAMES = 4;
  localparam int unsigned FB_AW      = 20;

  localparam logic [PIX_W-1:0] TRANSPARENT = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } spr_state_e;

endpackage

// File: rtl/sprite_draw_engine_if.sv
// Bus bundle for sprite_draw_engine.
//   Controller handshake : RUN_SPR, SPR_X, SPR_Y, SPR_FRAME, BACK_PAGE -> SPR_DONE
//   Sprite ROM           : ROM_ADDR -> ROM_DATA (synchronous, 1-cycle latency)
//   Framebuffer write    : FB_ADDR, FB_DATA, FB_WE
// slave = the draw engine, master = controller / ROM / framebuffer side.
interface sprite_draw_engine_if #(
  parameter int unsigned FRAME_W = $clog2(game_pkg::NUM_FRAMES),
  parameter int unsigned ROM_AW  = $clog2(game_pkg::NUM_FRAMES * game_pkg::SPR_W * game_pkg::SPR_H),
  parameter int unsigned PIX_W   = game_pkg::PIX_W,
  parameter int unsigned FB_AW   = game_pkg::FB_AW
);

  logic                     RUN_SPR;
  logic signed [10:0]       SPR_X;
  logic signed [9:0]        SPR_Y;
  logic [FRAME_W-1:0]       SPR_FRAME;
  logic                     BACK_PAGE;
  logic [ROM_AW-1:0]        ROM_ADDR;
  logic [PIX_W-1:0]         ROM_DATA;
  logic [FB_AW-1:0]         FB_ADDR;
  logic [PIX_W-1:0]         FB_DATA;
  logic                     FB_WE;
  logic                     SPR_DONE;

  modport master (
    output RUN_SPR, SPR_X, SPR_Y, SPR_FRAME, BACK_PAGE, ROM_DATA,
    input  ROM_ADDR, FB_ADDR, FB_DATA, FB_WE, SPR_DONE
  );

  modport slave (
    input  RUN_SPR, SPR_X, SPR_Y, SPR_FRAME, BACK_PAGE, ROM_DATA,
    output ROM_ADDR, FB_ADDR, FB_DATA, FB_WE, SPR_DONE
  );

endinterface

// File: rtl/sprite_clip_addr.sv
// Combinational screen clip and framebuffer address generator.
//   i_x, i_y     : signed 12-bit target pixel coordinates
//   i_page       : framebuffer page
//   o_on_screen  : 1 when 0 <= x < SCREEN_W and 0 <= y < SCREEN_H
//   o_fb_addr    : {page, y*SCREEN_W + x} (offset meaningful only on screen)
module sprite_clip_addr #(
  parameter int unsigned SCREEN_W = game_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = game_pkg::SCREEN_H
) (
  input  logic signed [11:0]              i_x,
  input  logic signed [11:0]              i_y,
  input  logic                            i_page,
  output logic                            o_on_screen,
  output logic [game_pkg::FB_AW-1:0]      o_fb_addr
);
  import game_pkg::*;

  localparam int unsigned OFF_W = FB_AW - 1;

  logic [OFF_W-1:0] w_offset;

  always_comb begin
    // Sign bit rejects negatives, so the upper-bound compares can be unsigned.
    o_on_screen = !i_x[11] && !i_y[11] &&
                  (i_x < 12'(SCREEN_W)) && (i_y < 12'(SCREEN_H));
    w_offset    = OFF_W'(i_y[9:0]) * OFF_W'(SCREEN_W) + OFF_W'(i_x[10:0]);
    o_fb_addr   = {i_page, w_offset};
  end

endmodule

// File: rtl/sprite_draw_engine.sv
// Sprite blitter: on RUN_SPR copies one SPR_W x SPR_H frame from sprite ROM
// into the back framebuffer page, skipping transparent (0) and off-screen
// pixels, then holds SPR_DONE until RUN_SPR drops.
//   CLOCK_50 : system clock
//   RESET_N  : synchronous active-low reset
//   bus      : controller handshake, sprite ROM port, framebuffer write port
module sprite_draw_engine #(
  parameter int unsigned SPR_W      = game_pkg::SPR_W,
  parameter int unsigned SPR_H      = game_pkg::SPR_H,
  parameter int unsigned NUM_FRAMES = game_pkg::NUM_FRAMES,
  parameter int unsigned SCREEN_W   = game_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H   = game_pkg::SCREEN_H,
  parameter int unsigned PIX_W      = game_pkg::PIX_W
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  sprite_draw_engine_if.slave  bus
);
  import game_pkg::*;

  localparam int unsigned COL_W   = $clog2(SPR_W);
  localparam int unsigned ROW_W   = $clog2(SPR_H);
  localparam int unsigned FRAME_W = $clog2(NUM_FRAMES);

  spr_state_e               r_state, w_next;
  logic [ROW_W-1:0]         r_row;
  logic [COL_W-1:0]         r_col;
  logic signed [10:0]       r_x0;
  logic signed [9:0]        r_y0;
  logic [FRAME_W-1:0]       r_frame;
  logic                     r_page;

  // Write-stage pipeline entry (target pixel of the previous ROM_ADDR cycle).
  logic                     r_pv;
  logic signed [11:0]       r_px;
  logic signed [11:0]       r_py;

  logic signed [11:0]       w_tx;
  logic signed [11:0]       w_ty;
  logic                     w_last;
  logic                     w_wr_stage;
  logic                     w_on_screen;
  logic [FB_AW-1:0]         w_fb_addr;

  assign w_tx       = {r_x0[10], r_x0} + 12'(r_col);
  assign w_ty       = {{2{r_y0[9]}}, r_y0} + 12'(r_row);
  assign w_last     = (&r_row) && (&r_col);
  assign w_wr_stage = r_pv && ((r_state == S_SCAN) || (r_state == S_DRAIN));

  sprite_clip_addr #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clip (
    .i_x         (r_px),
    .i_y         (r_py),
    .i_page      (r_page),
    .o_on_screen (w_on_screen),
    .o_fb_addr   (w_fb_addr)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    bus.ROM_ADDR = '0;
    bus.FB_ADDR  = '0;
    bus.FB_DATA  = '0;
    bus.FB_WE    = 1'b0;
    bus.SPR_DONE = 1'b0;

    case (r_state)
      S_IDLE:  if (bus.RUN_SPR) w_next = S_SCAN;
      S_SCAN:  if (!bus.RUN_SPR) w_next = S_IDLE;
               else if (w_last) w_next = S_DRAIN;
      S_DRAIN: w_next = bus.RUN_SPR ? S_DONE : S_IDLE;
      S_DONE:  if (!bus.RUN_SPR) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    // Power-of-2 geometry: frame*W*H + row*W + col is a plain concatenation.
    if (r_state == S_SCAN) bus.ROM_ADDR = {r_frame, r_row, r_col};

    if (w_wr_stage) begin
      bus.FB_ADDR = w_fb_addr;
      bus.FB_DATA = bus.ROM_DATA;
      bus.FB_WE   = w_on_screen && (bus.ROM_DATA != PIX_W'(TRANSPARENT));
    end

    bus.SPR_DONE = (r_state == S_DONE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_row   <= '0;
      r_col   <= '0;
      r_x0    <= '0;
      r_y0    <= '0;
      r_frame <= '0;
      r_page  <= 1'b0;
      r_pv    <= 1'b0;
      r_px    <= '0;
      r_py    <= '0;
    end else begin
      r_pv <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.RUN_SPR) begin
            r_x0    <= bus.SPR_X;
            r_y0    <= bus.SPR_Y;
            r_frame <= bus.SPR_FRAME;
            r_page  <= bus.BACK_PAGE;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        S_SCAN: begin
          if (bus.RUN_SPR) begin
            r_pv  <= 1'b1;
            r_px  <= w_tx;
            r_py  <= w_ty;
            r_col <= r_col + 1'b1;
            if (&r_col) r_row <= r_row + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_draw_engine.sv
module tb_sprite_draw_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sprite_draw_engine_if #(.FRAME_W(2), .ROM_AW(12), .PIX_W(8), .FB_AW(20)) bus ();

  sprite_draw_engine #(
    .SPR_W      (32),
    .SPR_H      (32),
    .NUM_FRAMES (4),
    .SCREEN_W   (640),
    .SCREEN_H   (480),
    .PIX_W      (8)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .bus      (bus)
  );

  // Synchronous sprite ROM model.
  logic [7:0] rom [4096];
  always @(posedge clk) bus.ROM_DATA <= rom[bus.ROM_ADDR];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // mode 0: opaque 0x05, 1: checkerboard 0/0x3C, 2: random with ~25% transparent
  task automatic fill_rom(input int mode);
    for (int i = 0; i < 4096; i++) begin
      logic [7:0] v;
      case (mode)
        0: v = 8'h05;
        1: v = (((i / 32) + (i % 32)) % 2 == 1) ? 8'h3C : 8'h00;
        default: begin
          v = 8'($urandom_range(1, 255));
          if ($urandom_range(0, 3) == 0) v = 8'h00;
        end
      endcase
      rom[i] = v;
    end
  endtask

  // Runs one draw. Cycle k is the k-th clock period after the edge that first
  // samples RUN_SPR high. stop_k > 0 drops RUN_SPR (or asserts reset when
  // use_reset) during cycle stop_k. exp_writes < 0 skips the total-count check.
  task automatic draw(input int sx, input int sy, input int fr, input int pg,
                      input int stop_k, input bit use_reset,
                      input int exp_writes, input int hold, input string name);
    int writes;
    int last_k;
    bus.SPR_X     = 11'(sx);
    bus.SPR_Y     = 10'(sy);
    bus.SPR_FRAME = 2'(fr);
    bus.BACK_PAGE = pg[0];
    bus.RUN_SPR   = 1'b1;
    @(posedge clk);
    #1;
    bus.SPR_X     = 11'($urandom);
    bus.SPR_Y     = 10'($urandom);
    bus.SPR_FRAME = 2'($urandom);
    bus.BACK_PAGE = 1'($urandom);
    writes = 0;
    last_k = (stop_k > 0) ? stop_k + 6 : 1026 + hold;
    for (int k = 1; k <= last_k; k++) begin
      bit  live;
      bit  exp_we;
      int  idx;
      int  exp_addr;
      int  exp_data;
      @(negedge clk);
      live     = (stop_k == 0) || (k <= stop_k);
      idx      = k - 2;
      exp_we   = 1'b0;
      exp_addr = 0;
      exp_data = 0;
      if (live && idx >= 0 && idx < 1024) begin
        int x, y, pix;
        x   = sx + idx % 32;
        y   = sy + idx / 32;
        pix = int'(rom[fr * 1024 + idx]);
        if (pix != 0 && x >= 0 && x < 640 && y >= 0 && y < 480) begin
          exp_we   = 1'b1;
          exp_addr = pg * 524288 + y * 640 + x;
          exp_data = pix;
        end
      end
      check($sformatf("%s we@%0d", name, k), bus.FB_WE, exp_we);
      if (exp_we && bus.FB_WE) begin
        check($sformatf("%s fb_addr@%0d", name, k), bus.FB_ADDR, exp_addr);
        check($sformatf("%s fb_data@%0d", name, k), bus.FB_DATA, exp_data);
      end
      if (bus.FB_WE) writes++;
      if (live && k <= 1024)
        check($sformatf("%s rom_addr@%0d", name, k), bus.ROM_ADDR, fr * 1024 + k - 1);
      check($sformatf("%s done@%0d", name, k), bus.SPR_DONE, (live && k >= 1026) ? 1 : 0);
      if (!live && use_reset) begin
        check($sformatf("%s rst_rom_addr@%0d", name, k), bus.ROM_ADDR, 0);
        check($sformatf("%s rst_fb_addr@%0d", name, k), bus.FB_ADDR, 0);
        check($sformatf("%s rst_fb_data@%0d", name, k), bus.FB_DATA, 0);
      end
      if (k == stop_k) begin
        if (use_reset) rst_n = 1'b0;
        else           bus.RUN_SPR = 1'b0;
      end
    end
    if (exp_writes >= 0) check($sformatf("%s writes", name), writes, exp_writes);
    bus.RUN_SPR = 1'b0;
    rst_n       = 1'b1;
    @(negedge clk);
    if (stop_k == 0) check($sformatf("%s done_drop", name), bus.SPR_DONE, 0);
    check($sformatf("%s idle_we", name), bus.FB_WE, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.RUN_SPR   = 1'b0;
    bus.SPR_X     = '0;
    bus.SPR_Y     = '0;
    bus.SPR_FRAME = '0;
    bus.BACK_PAGE = 1'b0;
    fill_rom(0);
    repeat (3) @(negedge clk);
    check("reset fb_we",    bus.FB_WE,    0);
    check("reset done",     bus.SPR_DONE, 0);
    check("reset rom_addr", bus.ROM_ADDR, 0);
    check("reset fb_addr",  bus.FB_ADDR,  0);
    check("reset fb_data",  bus.FB_DATA,  0);
    rst_n = 1'b1;
    @(negedge clk);

    // Opaque sprite, held 5 cycles past SPR_DONE.
    draw(100, 50, 2, 1, 0, 1'b0, 1024, 5, "opaque");

    fill_rom(1);
    draw(200, 100, int'($urandom_range(0, 3)), 0, 0, 1'b0, 512, 0, "checker");

    fill_rom(0);
    draw(-16, 470, 1, 1, 0, 1'b0, 160, 0, "clip");
    draw(700, 100, 3, 0, 0, 1'b0, 0, 0, "offscreen");

    fill_rom(2);
    draw(300, 200, 0, 1, 300, 1'b0, -1, 0, "abort");
    draw(50, 60, 2, 0, 100, 1'b1, -1, 0, "reset");

    for (int t = 0; t < 3; t++) begin
      fill_rom(2);
      draw(int'($urandom_range(0, 760)) - 60, int'($urandom_range(0, 560)) - 40,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
           0, 1'b0, -1, 0, $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
